psr_cond_unit: RTL and testbench
================================

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-015, with clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_psr  in  8  ALU flag byte {3'b0,Z,C,F,N,L}; bits [7:5] ignored.
REQ-005 flags_we  in  1  capture alu_psr[4:0] into the PSR this cycle.
REQ-006 psr_wr  in  1  load PSR from psr_wdata (LPR instruction).
REQ-007 psr_wdata  in  16  LPR source; only [4:0] used.
REQ-008 psr_rdata  out  16  {11'b0,Z,C,F,N,L}, the registered PSR (SPR instruction).
REQ-009 eval_req  in  1  condition evaluation request.
REQ-010 cond  in  4  condition code, sampled with eval_req.
REQ-011 eval_ready  out  1  block can accept eval_req this cycle.
REQ-012 taken_valid  out  1  evaluation result available.
REQ-013 taken  out  1  condition result; meaningful only while taken_valid=1.
REQ-014 taken_ack  in  1  consumer accepts the result.
REQ-015 taken_count  out  16  saturating count of accepted results with taken=1.

Function
REQ-016 The PSR SHALL be a 5-bit register {Z,C,F,N,L}; psr_wr takes priority over flags_we when both are high in the same cycle.
REQ-017 Condition decode SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never 0.
REQ-018 Evaluation SHALL use the bypassed next-PSR value: if psr_wr or flags_we is high in the request cycle, the newly written flags are used, with the REQ-016 priority applied.
REQ-019 The FSM SHALL have two states, IDLE and RESULT.
REQ-020 In IDLE, eval_ready=1 and taken_valid=0.
REQ-021 In IDLE, eval_req=1 SHALL move to RESULT on the next edge and register taken; latency is 1 cycle from request to taken_valid.
REQ-022 In RESULT, taken_valid=1, eval_ready=0, and taken and cond are held stable until taken_ack=1.
REQ-023 In RESULT, eval_req SHALL be ignored and no new evaluation started.
REQ-024 In RESULT, taken_ack=1 SHALL return the FSM to IDLE on the next edge.
REQ-025 A new request is accepted no earlier than the cycle after the ack, giving a minimum 2 cycles per evaluation.
REQ-026 taken_ack while in IDLE SHALL have no effect.
REQ-027 PSR writes in RESULT SHALL update the PSR but SHALL NOT change the held taken.
REQ-028 taken_count SHALL increment by 1 on each cycle with taken_valid & taken_ack & taken, and SHALL saturate at 16'hFFFF.
REQ-029 psr_rdata SHALL reflect the PSR register, not the bypass, so a write is visible one cycle after the write cycle.

Reset
REQ-030 reset=1 SHALL set the PSR to 0, the FSM to IDLE, taken to 0 and taken_count to 0, so outputs are psr_rdata=0, eval_ready=1 and taken_valid=0.
REQ-031 reset SHALL override all other inputs in the same cycle.
REQ-032 reset asserted while in RESULT SHALL discard the pending result without an ack.

Verification
REQ-033 Reset, then flags_we=1 with alu_psr=8'h10 -> next cycle psr_rdata=16'h0010; eval EQ -> taken_valid=1 and taken=1 one cycle later.
REQ-034 Same-cycle flags_we=1 (alu_psr=8'h01, L=1) and eval_req with cond=4 (HI) -> taken=1 via bypass; the same with psr_wr=1 and psr_wdata=0 also high -> taken=0 (psr_wr priority).
REQ-035 Sweep all 16 cond values against all 32 PSR values -> every result matches the REQ-017 table; cond F is always 0 and cond E is always 1.
REQ-036 Hold taken_ack=0 for 5 cycles in RESULT while toggling eval_req and writing the PSR -> taken is stable, eval_ready=0, and psr_rdata updates.
REQ-037 Preload taken_count to 16'hFFFE via 2 short runs of UC evals and acks, then 3 more UC evals and acks -> taken_count holds at 16'hFFFF.
REQ-038 Assert reset in RESULT -> next cycle taken_valid=0, eval_ready=1, psr_rdata=0, taken_count=0.

Source files
------------

// File: rtl/psr_cond_unit.sv
// ============================================================================
// psr_cond_unit
//
// Processor status register (PSR) plus branch-condition evaluator.
//
// The PSR holds five flags {Z,C,F,N,L}. It is loaded either from the ALU flag
// byte (flags_we) or from a software source operand (psr_wr, LPR). psr_wr has
// priority when both are high. psr_rdata always shows the registered PSR
// (SPR instruction).
//
// A condition evaluation is a valid/ready handshake with one result slot:
//   IDLE   : eval_ready=1; eval_req captures the result of cond against the
//            next-PSR value (same-cycle flag writes are bypassed in).
//   RESULT : taken_valid=1; taken is held until taken_ack. New requests are
//            ignored. PSR writes still land in the PSR but never disturb taken.
// Each accepted result with taken=1 bumps a saturating 16-bit counter.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high
//   alu_psr      in   8   {3'b0,Z,C,F,N,L} from the ALU; [7:5] ignored
//   flags_we     in   1   capture alu_psr[4:0] into the PSR
//   psr_wr       in   1   load PSR from psr_wdata[4:0]
//   psr_wdata    in  16   LPR source operand
//   psr_rdata    out 16   {11'b0,Z,C,F,N,L}
//   eval_req     in   1   evaluation request
//   cond         in   4   condition code, sampled with eval_req
//   eval_ready   out  1   request can be accepted this cycle
//   taken_valid  out  1   result available
//   taken        out  1   condition result (valid with taken_valid)
//   taken_ack    in   1   consumer accepts the result
//   taken_count  out 16   saturating count of accepted taken results
// ============================================================================
module psr_cond_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  alu_psr,
    input  logic        flags_we,
    input  logic        psr_wr,
    input  logic [15:0] psr_wdata,
    output logic [15:0] psr_rdata,
    input  logic        eval_req,
    input  logic [3:0]  cond,
    output logic        eval_ready,
    output logic        taken_valid,
    output logic        taken,
    input  logic        taken_ack,
    output logic [15:0] taken_count
);

    localparam int PSR_W = 5;
    localparam int CNT_W = 16;

    // Flag positions inside the PSR.
    localparam int Z_BIT = 4;
    localparam int C_BIT = 3;
    localparam int F_BIT = 2;
    localparam int N_BIT = 1;
    localparam int L_BIT = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        RESULT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Condition decode. L is the unsigned/ordered "greater" flag, N the signed
    // one, so LO/LT are "neither greater nor equal" and HS/GE include equal.
    // ------------------------------------------------------------------------
    function automatic logic cond_eval(input logic [3:0]       cc,
                                       input logic [PSR_W-1:0] p);
        logic z, c, f, n, l, r;
        z = p[Z_BIT];
        c = p[C_BIT];
        f = p[F_BIT];
        n = p[N_BIT];
        l = p[L_BIT];
        case (cc)
            4'h0:    r = z;            // EQ
            4'h1:    r = ~z;           // NE
            4'h2:    r = c;            // CS
            4'h3:    r = ~c;           // CC
            4'h4:    r = l;            // HI
            4'h5:    r = ~l;           // LS
            4'h6:    r = n;            // GT
            4'h7:    r = ~n;           // LE
            4'h8:    r = f;            // FS
            4'h9:    r = ~f;           // FC
            4'hA:    r = ~l & ~z;      // LO
            4'hB:    r = l | z;        // HS
            4'hC:    r = ~n & ~z;      // LT
            4'hD:    r = n | z;        // GE
            4'hE:    r = 1'b1;         // UC
            default: r = 1'b0;         // never
        endcase
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}})
            r = v;
        else
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    state_t             state_q;
    state_t             state_nxt;
    logic [PSR_W-1:0]   psr_q;
    logic [PSR_W-1:0]   psr_nxt;
    logic               taken_p1;
    logic [CNT_W-1:0]   count_q;
    logic               accept;
    logic               count_en;

    // Only the low five bits of either PSR source carry flags.
    logic               unused_bits;
    assign unused_bits = ^{alu_psr[7:PSR_W], psr_wdata[15:PSR_W]};

    // ------------------------------------------------------------------------
    // Next-PSR: this value is both the register input and the bypass used by
    // a same-cycle evaluation, so the LPR-over-ALU priority lives in one place.
    // ------------------------------------------------------------------------
    always_comb begin
        psr_nxt = psr_q;
        if (psr_wr)
            psr_nxt = psr_wdata[PSR_W-1:0];
        else if (flags_we)
            psr_nxt = alu_psr[PSR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            psr_q <= '0;
        else
            psr_q <= psr_nxt;
    end

    // ------------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Handshake FSM: next state and outputs
    always_comb begin
        state_nxt   = state_q;
        eval_ready  = 1'b0;
        taken_valid = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                eval_ready = 1'b1;
                if (eval_req) begin
                    accept    = 1'b1;
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                // eval_req is deliberately not looked at here; the slot is
                // full until the consumer acks.
                taken_valid = 1'b1;
                if (taken_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Result stage: taken is latched once on acceptance, so neither cond nor
    // later PSR writes can disturb it while it waits for the ack.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            taken_p1 <= 1'b0;
        else if (accept)
            taken_p1 <= cond_eval(cond, psr_nxt);
    end

    assign count_en = taken_valid & taken_ack & taken_p1;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (count_en)
            count_q <= sat_inc(count_q);
    end

    assign taken       = taken_p1;
    assign taken_count = count_q;
    assign psr_rdata   = {{(16-PSR_W){1'b0}}, psr_q};

endmodule

// File: tb/tb_psr_cond_unit.sv
// Self-checking bench for psr_cond_unit: scoreboard of expected taken values,
// one task per feature, single summary line at the end.
module tb_psr_cond_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  alu_psr;
    logic        flags_we;
    logic        psr_wr;
    logic [15:0] psr_wdata;
    logic [15:0] psr_rdata;
    logic        eval_req;
    logic [3:0]  cond;
    logic        eval_ready;
    logic        taken_valid;
    logic        taken;
    logic        taken_ack;
    logic [15:0] taken_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sbq[$];
    logic [4:0]  m_psr;
    logic [15:0] m_count;

    psr_cond_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_psr     (alu_psr),
        .flags_we    (flags_we),
        .psr_wr      (psr_wr),
        .psr_wdata   (psr_wdata),
        .psr_rdata   (psr_rdata),
        .eval_req    (eval_req),
        .cond        (cond),
        .eval_ready  (eval_ready),
        .taken_valid (taken_valid),
        .taken       (taken),
        .taken_ack   (taken_ack),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table, PSR = {Z,C,F,N,L}.
    function automatic bit model_cond(input logic [3:0] c, input logic [4:0] p);
        bit z, cf, f, n, l;
        z = p[4]; cf = p[3]; f = p[2]; n = p[1]; l = p[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and push the expected result computed from p_used.
    task automatic request(input logic [3:0] c, input logic [4:0] p_used);
        cond     = c;
        eval_req = 1'b1;
        sbq.push_back(model_cond(c, p_used));
    endtask

    // Pulse taken_ack for one edge and advance the counter model.
    task automatic ack_result(input bit was_taken);
        taken_ack = 1'b1;
        if (was_taken && m_count != 16'hFFFF)
            m_count = m_count + 16'd1;
        step();
        taken_ack = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must win over every other input in the same cycle.
        reset = 1'b1; flags_we = 1'b1; alu_psr = 8'hFF; psr_wr = 1'b1;
        psr_wdata = 16'hFFFF; eval_req = 1'b1; cond = 4'hE; taken_ack = 1'b1;
        step();
        step();
        reset = 1'b0; flags_we = 1'b0; psr_wr = 1'b0; eval_req = 1'b0;
        taken_ack = 1'b0; alu_psr = 8'h00; psr_wdata = 16'h0000;
        m_psr = 5'h00; m_count = 16'h0000;
        n_tests++; if (psr_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_psr: got %h expected %h", psr_rdata, 16'h0000); end
        n_tests++; if (eval_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", eval_ready); end
        n_tests++; if (taken_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", taken_valid); end
        n_tests++; if (taken_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", taken_count); end
        step();
        n_tests++; if (taken_valid !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: got %b expected 0", taken_valid); end
    endtask

    task automatic test_basic();
        bit exp;
        flags_we = 1'b1; alu_psr = 8'h10;
        step();
        flags_we = 1'b0; m_psr = 5'h10;
        n_tests++; if (psr_rdata !== 16'h0010) begin n_fail++; $display("FAIL basic_psr: got %h expected %h", psr_rdata, 16'h0010); end
        request(4'h0, m_psr);
        step();
        eval_req = 1'b0;
        n_tests++; if (taken_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid got %b expected 1", taken_valid); end
        n_tests++; if (eval_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready: got %b expected 0", eval_ready); end
        exp = sbq.pop_front();
        n_tests++; if (taken !== exp) begin n_fail++; $display("FAIL basic_eq: got %b expected %b", taken, exp); end
        ack_result(exp);
        n_tests++; if (taken_valid !== 1'b0 || eval_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ack: valid/ready got %b%b expected 01", taken_valid, eval_ready); end
        n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL basic_count: got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_bypass();
        bit exp;
        // ALU flags written in the request cycle: L=1 -> HI taken.
        flags_we = 1'b1; alu_psr = 8'h01;
        request(4'h4, 5'h01);
        #1;
        n_tests++; if (psr_rdata !== {11'b0, m_psr}) begin n_fail++; $display("FAIL bypass_rdata_unbypassed: got %h expected %h", psr_rdata, {11'b0, m_psr}); end
        step();
        flags_we = 1'b0; eval_req = 1'b0; m_psr = 5'h01;
        exp = sbq.pop_front();
        n_tests++; if (taken_valid !== 1'b1 || taken !== exp) begin n_fail++; $display("FAIL bypass_flags: valid/taken got %b%b expected 1%b", taken_valid, taken, exp); end
        ack_result(exp);
        // Both writes together: LPR of zero wins, so HI is not taken.
        flags_we = 1'b1; alu_psr = 8'h01; psr_wr = 1'b1; psr_wdata = 16'h0000;
        request(4'h4, 5'h00);
        step();
        flags_we = 1'b0; psr_wr = 1'b0; eval_req = 1'b0; m_psr = 5'h00;
        exp = sbq.pop_front();
        n_tests++; if (taken_valid !== 1'b1 || taken !== exp) begin n_fail++; $display("FAIL bypass_priority: valid/taken got %b%b expected 1%b", taken_valid, taken, exp); end
        n_tests++; if (psr_rdata !== 16'h0000) begin n_fail++; $display("FAIL bypass_priority_psr: got %h expected 0000", psr_rdata); end
        ack_result(exp);
        n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL bypass_count: got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_sweep();
        bit          exp;
        int          errs;
        logic [15:0] junk;
        errs = 0;
        for (int p = 0; p < 32; p++) begin
            for (int c = 0; c < 16; c++) begin
                int k;
                if (c == 0) begin
                    // Load the PSR via the bypass on the first code, with
                    // garbage in the unused upper bits.
                    junk = 16'($urandom);
                    psr_wr = 1'b1; psr_wdata = {junk[15:5], 5'(p)};
                end
                request(4'(c), 5'(p));
                step();
                psr_wr = 1'b0; eval_req = 1'b0; m_psr = 5'(p);
                k = 0;
                while (taken_valid !== 1'b1 && k < 4) begin
                    step();
                    k++;
                end
                exp = sbq.pop_front();
                n_tests++;
                if (taken_valid !== 1'b1 || taken !== exp) begin
                    n_fail++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL sweep_p%0h_c%0h: valid/taken got %b%b expected 1%b", p, c, taken_valid, taken, exp);
                end
                ack_result(exp);
            end
        end
        n_tests++; if (psr_rdata !== {11'b0, m_psr}) begin n_fail++; $display("FAIL sweep_psr: got %h expected %h", psr_rdata, {11'b0, m_psr}); end
        n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL sweep_count: got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_hold();
        bit         exp;
        logic [4:0] m_new;
        psr_wr = 1'b1; psr_wdata = 16'h0010;
        request(4'h0, 5'h10);
        step();
        psr_wr = 1'b0; eval_req = 1'b0; m_psr = 5'h10;
        exp = sbq.pop_front();
        n_tests++; if (taken_valid !== 1'b1 || taken !== exp) begin n_fail++; $display("FAIL hold_start: valid/taken got %b%b expected 1%b", taken_valid, taken, exp); end
        for (int i = 0; i < 5; i++) begin
            eval_req = (i % 2 == 0);
            cond     = 4'(i + 1);
            if (i % 2 == 0) begin
                m_new = 5'(i * 2 + 1);
                flags_we = 1'b1; alu_psr = {3'b111, m_new};
            end else begin
                m_new = 5'(i + 8);
                psr_wr = 1'b1; psr_wdata = {11'h7FF, m_new};
            end
            step();
            flags_we = 1'b0; psr_wr = 1'b0; m_psr = m_new;
            n_tests++;
            if (taken_valid !== 1'b1 || eval_ready !== 1'b0 || taken !== exp) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: valid/ready/taken got %b%b%b expected 10%b", i, taken_valid, eval_ready, taken, exp);
            end
            n_tests++; if (psr_rdata !== {11'b0, m_psr}) begin n_fail++; $display("FAIL hold_psr_cyc%0d: got %h expected %h", i, psr_rdata, {11'b0, m_psr}); end
        end
        eval_req = 1'b0;
        ack_result(exp);
        n_tests++; if (taken_count !== m_count || eval_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ack: count got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_back_to_back();
        bit exp;
        request(4'hE, m_psr);
        step();
        eval_req = 1'b0;
        exp = sbq.pop_front();
        // Ack and a fresh request together: the request must be dropped.
        taken_ack = 1'b1; eval_req = 1'b1; cond = 4'hF;
        if (exp) m_count = m_count + 16'd1;
        step();
        taken_ack = 1'b0;
        n_tests++; if (taken_valid !== 1'b0 || eval_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_dropped: valid/ready got %b%b expected 01", taken_valid, eval_ready); end
        request(4'hE, m_psr);
        step();
        eval_req = 1'b0;
        exp = sbq.pop_front();
        n_tests++; if (taken_valid !== 1'b1 || taken !== exp) begin n_fail++; $display("FAIL b2b_second: valid/taken got %b%b expected 1%b", taken_valid, taken, exp); end
        ack_result(exp);
        n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL b2b_count: got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_ack_idle();
        taken_ack = 1'b1;
        step();
        step();
        taken_ack = 1'b0;
        n_tests++; if (taken_valid !== 1'b0 || eval_ready !== 1'b1) begin n_fail++; $display("FAIL ackidle_state: valid/ready got %b%b expected 01", taken_valid, eval_ready); end
        n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL ackidle_count: got %h expected %h", taken_count, m_count); end
    endtask

    task automatic test_saturate();
        bit exp;
        // First short run: ordinary increments.
        for (int i = 0; i < 2; i++) begin
            request(4'hE, m_psr);
            step();
            eval_req = 1'b0;
            exp = sbq.pop_front();
            ack_result(exp);
            n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL sat_run1_%0d: got %h expected %h", i, taken_count, m_count); end
        end
        // Second run is replaced by a direct preload to keep the bench short.
        force dut.count_q = 16'hFFFE;
        step();
        release dut.count_q;
        m_count = 16'hFFFE;
        n_tests++; if (taken_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected FFFE", taken_count); end
        for (int i = 0; i < 3; i++) begin
            request(4'hE, m_psr);
            step();
            eval_req = 1'b0;
            exp = sbq.pop_front();
            n_tests++; if (taken !== exp) begin n_fail++; $display("FAIL sat_taken_%0d: got %b expected %b", i, taken, exp); end
            ack_result(exp);
            n_tests++; if (taken_count !== m_count) begin n_fail++; $display("FAIL sat_count_%0d: got %h expected %h", i, taken_count, m_count); end
        end
    endtask

    task automatic test_reset_in_result();
        bit exp;
        psr_wr = 1'b1; psr_wdata = 16'h001F;
        request(4'hE, 5'h1F);
        step();
        psr_wr = 1'b0; eval_req = 1'b0; m_psr = 5'h1F;
        n_tests++; if (taken_valid !== 1'b1) begin n_fail++; $display("FAIL rstres_pending: valid got %b expected 1", taken_valid); end
        exp = sbq.pop_front();
        reset = 1'b1; eval_req = 1'b1; cond = 4'hE; flags_we = 1'b1; alu_psr = 8'h1F;
        step();
        reset = 1'b0; eval_req = 1'b0; flags_we = 1'b0;
        m_psr = 5'h00; m_count = 16'h0000;
        n_tests++; if (taken_valid !== 1'b0 || eval_ready !== 1'b1) begin n_fail++; $display("FAIL rstres_state: valid/ready got %b%b expected 01", taken_valid, eval_ready); end
        n_tests++; if (psr_rdata !== 16'h0000) begin n_fail++; $display("FAIL rstres_psr: got %h expected 0000", psr_rdata); end
        n_tests++; if (taken_count !== 16'h0000) begin n_fail++; $display("FAIL rstres_count: got %h expected 0000", taken_count); end
        n_tests++; if (taken !== 1'b0) begin n_fail++; $display("FAIL rstres_taken: got %b expected 0 (discarded %b)", taken, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; alu_psr = '0; flags_we = 1'b0; psr_wr = 1'b0;
        psr_wdata = '0; eval_req = 1'b0; cond = '0; taken_ack = 1'b0;
        m_psr = '0; m_count = '0;
        test_reset();
        test_basic();
        test_bypass();
        test_sweep();
        test_hold();
        test_back_to_back();
        test_ack_idle();
        test_saturate();
        test_reset_in_result();
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
